// File: rtl/wsg_pkg.sv
// Shared constants, FSM states and the per-voice arithmetic for the Namco
// waveform sound generator.
package wsg_pkg;

  localparam int ACC_W = 20;
  localparam int VOICE_STRIDE = 5;

  localparam logic [4:0] WAVE_OFS  = 5'h05;
  localparam logic [4:0] FREQ0_OFS = 5'h10;
  localparam logic [4:0] VOL_OFS   = 5'h15;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    ACC,
    OUT
  } wsg_state_t;

  // PROM nibbles are offset-binary; centre them on zero before scaling by volume.
  function automatic logic signed [9:0] voice_term(input logic [3:0] vol,
                                                   input logic [3:0] d);
    logic signed [9:0] centered;
    logic signed [9:0] scale;
    centered = $signed({6'b000000, d}) - 10'sd8;
    scale    = $signed({6'b000000, vol});
    return scale * centered;
  endfunction

endpackage

// File: rtl/wsg_regfile.sv
// 32x4 sound register file with its CPU write port and the decoded
// per-voice wave / frequency / volume views.
module wsg_regfile
  import wsg_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       we,
  input  logic [4:0]                 addr,
  input  logic [3:0]                 din,
  output logic [2:0][3:0]            wave,
  output logic [2:0][ACC_W-1:0]      freq,
  output logic [2:0][3:0]            vol
);

  logic [31:0][3:0] regs;

  always_ff @(posedge clk) begin
    if (reset) begin
      regs <= '0;
    end else if (we) begin
      regs[addr] <= din;
    end
  end

  // Only voice 0 owns a low frequency nibble; the others are implicitly zero.
  for (genvar v = 0; v < 3; v++) begin : g_voice
    localparam logic [4:0] OFS    = 5'(v * VOICE_STRIDE);
    localparam bit         HAS_LO = (v == 0);

    assign wave[v] = regs[WAVE_OFS + OFS];
    assign vol[v]  = regs[VOL_OFS + OFS];
    assign freq[v] = {regs[FREQ0_OFS + OFS + 5'd4],
                      regs[FREQ0_OFS + OFS + 5'd3],
                      regs[FREQ0_OFS + OFS + 5'd2],
                      regs[FREQ0_OFS + OFS + 5'd1],
                      HAS_LO ? regs[FREQ0_OFS] : 4'h0};
  end

endmodule

// File: rtl/namco_wsg.sv
// Three-voice Namco WSG: frame divider plus a sequencer that shares the wave
// PROMs between voices and accumulates one mixed signed sample per frame.
module namco_wsg
  import wsg_pkg::*;
#(
  parameter int CLK_HZ    = 34800000,
  parameter int SAMPLE_HZ = 96000
)
(
  input  logic       clk,
  input  logic       reset,
  input  logic       reg_we,
  input  logic [4:0] reg_addr,
  input  logic [3:0] reg_din,
  input  logic       snd_en,
  output logic       rom_rd,
  output logic [7:0] rom_addr,
  output logic       rom_bank,
  input  logic [3:0] rom_data_a,
  input  logic [3:0] rom_data_b,
  output logic [9:0] sample,
  output logic       sample_valid
);

  localparam int FRAME_DIV = CLK_HZ / SAMPLE_HZ;
  localparam int DIV_W     = $clog2(FRAME_DIV);

  // A frame takes 10 cycles from its start tick plus the registered strobe.
  if (FRAME_DIV < 12) begin : g_bad_frame_div
    $error("namco_wsg: FRAME_DIV must be at least 12");
  end

  logic [2:0][3:0]       wave;
  logic [2:0][ACC_W-1:0] freq;
  logic [2:0][3:0]       vol;

  wsg_regfile u_regfile (
    .clk   (clk),
    .reset (reset),
    .we    (reg_we),
    .addr  (reg_addr),
    .din   (reg_din),
    .wave  (wave),
    .freq  (freq),
    .vol   (vol)
  );

  logic [DIV_W-1:0] div_cnt;
  logic             frame_tick;

  assign frame_tick = (div_cnt == DIV_W'(FRAME_DIV - 1));

  always_ff @(posedge clk) begin
    if (reset || frame_tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  wsg_state_t            state;
  logic [1:0]            voice;
  logic [2:0][ACC_W-1:0] acc;
  logic signed [9:0]     sum;
  logic [3:0]            rom_d;

  // rom_bank is held from the fetch, so it still selects the PROM in ACC.
  assign rom_d = rom_bank ? rom_data_b : rom_data_a;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      voice        <= '0;
      acc          <= '0;
      sum          <= '0;
      sample       <= '0;
      sample_valid <= 1'b0;
      rom_rd       <= 1'b0;
      rom_addr     <= '0;
      rom_bank     <= 1'b0;
    end else begin
      rom_rd       <= 1'b0;
      sample_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (frame_tick) begin
            state <= FETCH;
            voice <= '0;
            sum   <= '0;
          end
        end
        FETCH: begin
          rom_rd   <= 1'b1;
          rom_addr <= {wave[voice][2:0], acc[voice][ACC_W-1 -: 5]};
          rom_bank <= wave[voice][3];
          state    <= WAIT;
        end
        WAIT: begin
          state <= ACC;
        end
        ACC: begin
          sum        <= sum + voice_term(vol[voice], rom_d);
          acc[voice] <= acc[voice] + freq[voice];
          if (voice == 2'd2) begin
            state <= OUT;
          end else begin
            voice <= voice + 2'd1;
            state <= FETCH;
          end
        end
        OUT: begin
          sample       <= snd_en ? sum : '0;
          sample_valid <= 1'b1;
          state        <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_namco_wsg.sv
// Directed self-checking bench for namco_wsg with a small registered wave-PROM model.
module tb_namco_wsg;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       reg_we = 1'b0;
  logic [4:0] reg_addr = '0;
  logic [3:0] reg_din = '0;
  logic       snd_en = 1'b1;
  logic       rom_rd;
  logic [7:0] rom_addr;
  logic       rom_bank;
  logic [3:0] rom_data_a = '0;
  logic [3:0] rom_data_b = '0;
  logic [9:0] sample;
  logic       sample_valid;

  int checks = 0;
  int fails = 0;

  logic       use_pattern = 1'b1;
  logic [3:0] const_a = '0;
  logic [3:0] const_b = '0;

  namco_wsg #(.CLK_HZ(1200000), .SAMPLE_HZ(100000)) dut (
    .clk          (clk),
    .reset        (reset),
    .reg_we       (reg_we),
    .reg_addr     (reg_addr),
    .reg_din      (reg_din),
    .snd_en       (snd_en),
    .rom_rd       (rom_rd),
    .rom_addr     (rom_addr),
    .rom_bank     (rom_bank),
    .rom_data_a   (rom_data_a),
    .rom_data_b   (rom_data_b),
    .sample       (sample),
    .sample_valid (sample_valid)
  );

  always #5 clk = ~clk;

  // Pattern mode returns the sample index (low 4 bits) as the PROM nibble.
  always @(posedge clk) begin
    if (rom_rd) begin
      rom_data_a <= use_pattern ? rom_addr[3:0] : const_a;
      rom_data_b <= use_pattern ? rom_addr[3:0] : const_b;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic write_reg(input logic [4:0] a, input logic [3:0] d);
    reg_we   = 1'b1;
    reg_addr = a;
    reg_din  = d;
    @(negedge clk);
    reg_we   = 1'b0;
  endtask

  task automatic wait_frame();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (sample_valid) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      fails++;
      $display("[TB] FAIL frame_timeout: got no sample_valid, expected one within 40 cycles");
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reg_we = 1'b0;
    reset  = 1'b1;
    repeat (2) @(negedge clk);
    reset  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    checks += 5;
    if (sample !== 10'd0) begin fails++; $display("[TB] FAIL reset_sample: got %h expected 000", sample); end
    if (sample_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_valid: got %b expected 0", sample_valid); end
    if (rom_rd !== 1'b0) begin fails++; $display("[TB] FAIL reset_rom_rd: got %b expected 0", rom_rd); end
    if (rom_addr !== 8'd0) begin fails++; $display("[TB] FAIL reset_rom_addr: got %h expected 00", rom_addr); end
    if (rom_bank !== 1'b0) begin fails++; $display("[TB] FAIL reset_rom_bank: got %b expected 0", rom_bank); end
  endtask

  task automatic test_idle_frames();
    int gap;
    int reads;
    wait_frame();
    for (int f = 0; f < 2; f++) begin
      gap = 0;
      reads = 0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        gap++;
        if (rom_rd) reads++;
        if (sample_valid) break;
      end
      checks += 3;
      if (gap != 12) begin fails++; $display("[TB] FAIL idle_period: got %0d expected 12", gap); end
      if (reads != 3) begin fails++; $display("[TB] FAIL idle_rom_reads: got %0d expected 3", reads); end
      if (sample !== 10'd0) begin fails++; $display("[TB] FAIL idle_sample: got %h expected 000", sample); end
    end
  endtask

  task automatic test_voice0_ramp();
    int expv;
    use_pattern = 1'b1;
    wait_frame();
    write_reg(5'h15, 4'd15);
    write_reg(5'h13, 4'd8);
    for (int k = 0; k < 34; k++) begin
      wait_frame();
      expv = 15 * ((k % 16) - 8);
      checks++;
      if (sample !== 10'(expv)) begin
        fails++;
        $display("[TB] FAIL ramp_frame%0d: got %0d expected %0d", k, $signed(sample), expv);
      end
    end
  endtask

  task automatic test_bank_select();
    bit seen;
    use_pattern = 1'b0;
    const_a = 4'd0;
    const_b = 4'd15;
    wait_frame();
    write_reg(5'h05, 4'd9);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (rom_rd) seen = 1'b1;
    end
    checks += 3;
    if (!seen) begin fails++; $display("[TB] FAIL bank_rom_rd: got no rom_rd, expected one"); end
    if (rom_bank !== 1'b1) begin fails++; $display("[TB] FAIL bank_sel: got %b expected 1", rom_bank); end
    if (rom_addr[7:5] !== 3'b001) begin fails++; $display("[TB] FAIL bank_wave_bits: got %b expected 001", rom_addr[7:5]); end
    wait_frame();
    checks++;
    if (sample !== 10'd105) begin fails++; $display("[TB] FAIL bank_sample: got %0d expected 105", $signed(sample)); end
  endtask

  task automatic test_full_scale();
    wait_frame();
    const_a = 4'd0;
    const_b = 4'd0;
    write_reg(5'h1A, 4'd15);
    write_reg(5'h1F, 4'd15);
    wait_frame();
    wait_frame();
    checks++;
    if (sample !== 10'h298) begin fails++; $display("[TB] FAIL full_negative: got %h expected 298", sample); end
    const_a = 4'd15;
    const_b = 4'd15;
    wait_frame();
    checks++;
    if (sample !== 10'h13B) begin fails++; $display("[TB] FAIL full_positive: got %h expected 13b", sample); end
  endtask

  task automatic test_snd_enable();
    use_pattern = 1'b1;
    snd_en = 1'b1;
    pulse_reset();
    wait_frame();
    write_reg(5'h15, 4'd15);
    write_reg(5'h13, 4'd8);
    wait_frame();
    checks++;
    if (sample !== 10'(-120)) begin fails++; $display("[TB] FAIL en_first: got %0d expected -120", $signed(sample)); end
    snd_en = 1'b0;
    for (int f = 0; f < 4; f++) begin
      wait_frame();
      checks++;
      if (sample !== 10'd0) begin fails++; $display("[TB] FAIL en_muted%0d: got %0d expected 0", f, $signed(sample)); end
    end
    snd_en = 1'b1;
    wait_frame();
    checks++;
    if (sample !== 10'(-45)) begin fails++; $display("[TB] FAIL en_resume: got %0d expected -45", $signed(sample)); end
  endtask

  task automatic test_reset_mid_frame();
    int reads;
    bit strobe;
    bit nonzero;
    bit seen;
    wait_frame();
    reads = 0;
    for (int i = 0; i < 20 && reads < 2; i++) begin
      @(negedge clk);
      if (rom_rd) reads++;
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks += 3;
    if (sample !== 10'd0) begin fails++; $display("[TB] FAIL midreset_sample: got %h expected 000", sample); end
    if (rom_rd !== 1'b0) begin fails++; $display("[TB] FAIL midreset_rom_rd: got %b expected 0", rom_rd); end
    if (rom_addr !== 8'd0) begin fails++; $display("[TB] FAIL midreset_rom_addr: got %h expected 00", rom_addr); end
    strobe = 1'b0;
    nonzero = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (sample_valid) strobe = 1'b1;
      if (sample !== 10'd0) nonzero = 1'b1;
    end
    checks += 2;
    if (strobe) begin fails++; $display("[TB] FAIL midreset_no_strobe: got strobe 1 expected 0"); end
    if (nonzero) begin fails++; $display("[TB] FAIL midreset_hold_zero: got nonzero sample %h expected 000", sample); end
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (rom_rd) seen = 1'b1;
    end
    checks++;
    if (!seen || rom_addr !== 8'd0) begin fails++; $display("[TB] FAIL midreset_next_addr: got %h (rd seen %b) expected 00", rom_addr, seen); end
    wait_frame();
    checks++;
    if (sample !== 10'd0) begin fails++; $display("[TB] FAIL midreset_next_sample: got %0d expected 0", $signed(sample)); end
  endtask

  initial begin
    test_reset();
    test_idle_frames();
    test_voice0_ramp();
    test_bank_select();
    test_full_scale();
    test_snd_enable();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
